// File: rtl/l1d_cache_param.sv
// l1d_cache_param: set-associative, write-back / write-allocate L1 data cache
// with true-LRU replacement, sitting between the CPU load/store port and a
// single-word memory bus that supports burst writeback and burst refill.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cpu_req_*             CPU request (valid/ready, store flag, word-aligned
//                         byte address, store data, byte strobes)
//   cpu_resp_valid/rdata  one-cycle response pulse; rdata is 0 for stores
//   mem_req_*             memory request: line read (store=0) or one
//                         writeback beat (store=1), held until mem_req_ready
//   mem_rdata_valid/rdata refill beats, delivered in word order
//
// Optional build macro L1D_PERF_CNT_EN adds hit_cnt / miss_cnt outputs that
// count lookup hits and misses.
module l1d_cache_param #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SETS       = 64,
    parameter int WAYS       = 4,
    parameter int LINE_WORDS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req_valid,
    output logic                cpu_req_ready,
    input  logic                cpu_req_store,
    input  logic [ADDR_W-1:0]   cpu_req_addr,
    input  logic [DATA_W-1:0]   cpu_req_wdata,
    input  logic [DATA_W/8-1:0] cpu_req_wstrb,
    output logic                cpu_resp_valid,
    output logic [DATA_W-1:0]   cpu_resp_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_store,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    input  logic                mem_rdata_valid,
`ifdef L1D_PERF_CNT_EN
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt,
`endif
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int SB = DATA_W / 8;
    localparam int BO = $clog2(SB);
    localparam int WO = $clog2(LINE_WORDS);
    localparam int IW = $clog2(SETS);
    localparam int WW = $clog2(WAYS);
    localparam int AW = ADDR_W - BO;           // word address width
    localparam int TW = AW - WO - IW;
    localparam logic [WO-1:0] LAST_BEAT = WO'(LINE_WORDS - 1);
    localparam logic [WW-1:0] LRU_POS   = WW'(WAYS - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, REFILL_REQ, REFILL, RESP} state_t;

    // storage
    logic [DATA_W-1:0] data_q [SETS][WAYS][LINE_WORDS];
    logic [TW-1:0]     tag_q  [SETS][WAYS];
    logic [WAYS-1:0]   vld_q  [SETS];
    logic [WAYS-1:0]   dirty_q[SETS];
    logic [WW-1:0]     lru_q  [SETS][WAYS];

    // latched request (byte offset dropped: requests are word aligned)
    state_t          state;
    logic            req_store;
    logic [AW-1:0]   req_waddr;
    logic [DATA_W-1:0] req_wdata;
    logic [SB-1:0]   req_wstrb;
    logic [WW-1:0]   acc_way;
    logic [WO-1:0]   beat;

    logic [WO-1:0]   req_word;
    logic [IW-1:0]   req_idx;
    logic [TW-1:0]   req_tag;
    logic [WO-1:0]   beat_nxt;
    assign req_word = req_waddr[WO-1:0];
    assign req_idx  = req_waddr[WO+IW-1:WO];
    assign req_tag  = req_waddr[AW-1:WO+IW];
    assign beat_nxt = beat + 1'b1;

    logic unused_lsb;
    assign unused_lsb = ^cpu_req_addr[BO-1:0];

    // tag compare and victim choice
    logic          hit, has_inv;
    logic [WW-1:0] hit_way, inv_way, lru_way, vict_way;
    always_comb begin
        hit = 1'b0; hit_way = '0; has_inv = 1'b0; inv_way = '0; lru_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && vld_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit = 1'b1; hit_way = WW'(w);
            end
            if (lru_q[req_idx][w] == LRU_POS) lru_way = WW'(w);
        end
        // descending scan so the lowest-index invalid way wins
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!vld_q[req_idx][w]) begin
                has_inv = 1'b1; inv_way = WW'(w);
            end
        end
        vict_way = has_inv ? inv_way : lru_way;
    end

    // byte-strobe merge of the store into the accessed word
    logic [DATA_W-1:0] cur_word, merged;
    always_comb begin
        cur_word = data_q[req_idx][acc_way][req_word];
        merged   = cur_word;
        for (int b = 0; b < SB; b++)
            if (req_wstrb[b]) merged[b*8 +: 8] = req_wdata[b*8 +: 8];
    end

    // data/tag arrays need no reset; validity is tracked by vld_q
    always_ff @(posedge clk) begin
        if (state == REFILL && mem_rdata_valid) begin
            data_q[req_idx][acc_way][beat] <= mem_rdata;
            if (beat == LAST_BEAT) tag_q[req_idx][acc_way] <= req_tag;
        end else if (state == RESP && req_store) begin
            data_q[req_idx][acc_way][req_word] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cpu_req_ready  <= 1'b0;
            cpu_resp_valid <= 1'b0;
            cpu_resp_rdata <= '0;
            mem_req_valid  <= 1'b0;
            mem_req_store  <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_wdata  <= '0;
            req_store      <= 1'b0;
            req_waddr      <= '0;
            req_wdata      <= '0;
            req_wstrb      <= '0;
            acc_way        <= '0;
            beat           <= '0;
            for (int s = 0; s < SETS; s++) begin
                vld_q[s]   <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) lru_q[s][w] <= WW'(w);
            end
`ifdef L1D_PERF_CNT_EN
            hit_cnt  <= '0;
            miss_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // ready is raised one cycle after reset release
                    if (cpu_req_valid && cpu_req_ready) begin
                        cpu_req_ready <= 1'b0;
                        req_store     <= cpu_req_store;
                        req_waddr     <= cpu_req_addr[ADDR_W-1:BO];
                        req_wdata     <= cpu_req_wdata;
                        req_wstrb     <= cpu_req_wstrb;
                        state         <= LOOKUP;
                    end else begin
                        cpu_req_ready <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        acc_way        <= hit_way;
                        cpu_resp_valid <= 1'b1;
                        cpu_resp_rdata <= req_store ? '0 : data_q[req_idx][hit_way][req_word];
                        state          <= RESP;
`ifdef L1D_PERF_CNT_EN
                        hit_cnt <= hit_cnt + 1'b1;
`endif
                    end else begin
                        acc_way       <= vict_way;
                        beat          <= '0;
                        mem_req_valid <= 1'b1;
`ifdef L1D_PERF_CNT_EN
                        miss_cnt <= miss_cnt + 1'b1;
`endif
                        if (vld_q[req_idx][vict_way] && dirty_q[req_idx][vict_way]) begin
                            mem_req_store <= 1'b1;
                            mem_req_addr  <= {tag_q[req_idx][vict_way], req_idx, {WO{1'b0}}, {BO{1'b0}}};
                            mem_req_wdata <= data_q[req_idx][vict_way][0];
                            state         <= WB;
                        end else begin
                            // the victim's contents are about to be overwritten
                            vld_q[req_idx][vict_way]   <= 1'b0;
                            dirty_q[req_idx][vict_way] <= 1'b0;
                            mem_req_store <= 1'b0;
                            mem_req_addr  <= {req_tag, req_idx, {WO{1'b0}}, {BO{1'b0}}};
                            state         <= REFILL_REQ;
                        end
                    end
                end
                WB: begin
                    if (mem_req_ready) begin
                        if (beat == LAST_BEAT) begin
                            vld_q[req_idx][acc_way]   <= 1'b0;
                            dirty_q[req_idx][acc_way] <= 1'b0;
                            beat          <= '0;
                            mem_req_store <= 1'b0;
                            mem_req_addr  <= {req_tag, req_idx, {WO{1'b0}}, {BO{1'b0}}};
                            mem_req_wdata <= '0;
                            state         <= REFILL_REQ;
                        end else begin
                            beat          <= beat_nxt;
                            mem_req_addr  <= {tag_q[req_idx][acc_way], req_idx, beat_nxt, {BO{1'b0}}};
                            mem_req_wdata <= data_q[req_idx][acc_way][beat_nxt];
                        end
                    end
                end
                REFILL_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_req_addr  <= '0;
                        beat          <= '0;
                        state         <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_rdata_valid) begin
                        // capture the requested word as it streams past
                        if (beat == req_word) cpu_resp_rdata <= req_store ? '0 : mem_rdata;
                        beat <= beat_nxt;
                        if (beat == LAST_BEAT) begin
                            vld_q[req_idx][acc_way]   <= 1'b1;
                            dirty_q[req_idx][acc_way] <= 1'b0;
                            cpu_resp_valid <= 1'b1;
                            state          <= RESP;
                        end
                    end
                end
                RESP: begin
                    cpu_resp_valid <= 1'b0;
                    cpu_resp_rdata <= '0;
                    if (req_store) dirty_q[req_idx][acc_way] <= 1'b1;
                    for (int w = 0; w < WAYS; w++) begin
                        if (WW'(w) == acc_way)
                            lru_q[req_idx][w] <= '0;
                        else if (lru_q[req_idx][w] < lru_q[req_idx][acc_way])
                            lru_q[req_idx][w] <= lru_q[req_idx][w] + 1'b1;
                    end
                    cpu_req_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
